sevenseg_deserializer: RTL and testbench
========================================

# sevenseg_deserializer

Receive-side counterpart of the 7-segment serial link: samples a one-bit data line and an active-low group latch, rebuilds four 16-bit words per 64-bit frame, and presents them as a registered parallel frame. Sits at the display end of the link, or in the test harness as a link monitor. Enforces strict 16-bit framing and flags any framing violation. Incomplete frames are never exposed.

## Interface
Parameters:
- none (frame format is fixed: 4 groups × 16 bits, LSB first)

Ports:
- i_CLK  input  1  link clock; every action occurs on its rising edge.
- i_RESET_N  input  1  asynchronous, active-low reset.
- i_EN  input  1  bit qualifier; i_7SegData and i_7Seg_Latch are ignored on edges where i_EN=0.
- i_7SegData  input  1  serial data; the first bit of each group is bit 0.
- i_7Seg_Latch  input  1  active low; low on the edge that carries bit 15 of a group.
- o_7SegData16_0  output  16  group 0 of the last complete frame (bits 0–15 on the wire).
- o_7SegData16_1  output  16  group 1 (wire bits 16–31).
- o_7SegData16_2  output  16  group 2 (wire bits 32–47).
- o_7SegData16_3  output  16  group 3 (wire bits 48–63).
- o_FrameValid  output  1  one-cycle pulse when the four outputs update.
- o_SyncErr  output  1  one-cycle pulse on a framing violation.

## Operation
- State: shift register sh[15:0], bit counter bcnt[3:0], group counter gcnt[1:0], staging words stg0..stg2, output words, and the two pulse registers.
- An accepted edge is a rising edge with i_EN=1. Nothing changes on other edges except the pulses, which clear.
- On an accepted edge, let w = {i_7SegData, sh[15:1]} (right shift, so the first bit received lands in bit 0).
- Case bcnt<15 and latch high: sh←w, bcnt←bcnt+1.
- Case bcnt==15 and latch low (good group end): the word is w.
  - If gcnt<3: stg[gcnt]←w, gcnt←gcnt+1.
  - If gcnt==3: o_7SegData16_0..2←stg0..2 and o_7SegData16_3←w, all on the same edge. Pulse o_FrameValid. gcnt←0.
  - In both sub-cases bcnt←0.
- Case bcnt<15 and latch low (early latch): violation.
- Case bcnt==15 and latch high (missing latch): violation.
- On a violation: pulse o_SyncErr, set bcnt←0 and gcnt←0, discard the partial frame, and leave the outputs unchanged. The bit sampled on that edge is dropped; resync starts on the next accepted edge.
- Outputs change only on a frame completion or on reset. The four words always come from a single frame.

## Timing
- Reset (async assert, released synchronously by the integrator): all outputs 0, sh/bcnt/gcnt/stg all 0, no pulses.
- Reset asserted mid-frame clears everything immediately, including the outputs. The first accepted edge after release is bit 0 of group 0.
- Latency: outputs and o_FrameValid become valid in the cycle after the edge that samples wire bit 63. o_FrameValid is high for exactly that one cycle.
- Minimum frame spacing is 64 accepted edges; back-to-back frames are supported with no gap cycles.
- o_SyncErr is high for exactly the cycle after the offending edge. o_FrameValid and o_SyncErr are never high together.
- i_EN gaps may occur anywhere, including between bit 15 and the next bit 0; the counters hold across gaps.
- bcnt never wraps silently: its 15→0 transition happens only on a good latch or on a violation.
- Upstream contract: data and latch are stable around the rising edge. The latch is low for exactly one accepted edge per group.

## Test plan
- Reset, then send frame 0x1234, 0xABCD, 0x0F0F, 0x8001 LSB-first with correct latches, i_EN=1 continuously → outputs hold 0 until the cycle after bit 63, then show those four values; one o_FrameValid pulse; no o_SyncErr.
- After a good frame, drive the latch low at bit 10 of group 1 → one o_SyncErr pulse, no o_FrameValid, outputs keep the previous frame. Then send a clean frame 0x5555, 0xAAAA, 0x0001, 0xFFFF → received exactly.
- Omit the latch on bit 15 of group 2 → o_SyncErr in the cycle after that edge; the partial frame is discarded; the next clean frame is correct.
- Same frame as the first scenario, with i_EN=0 for 3 cycles at bit 7 of group 0 and for 5 cycles between groups 2 and 3 → identical outputs; o_FrameValid delayed by exactly 8 cycles.
- Assert i_RESET_N=0 mid-cycle after 40 bits of a frame, while the outputs hold an earlier frame → outputs drop to 0 without waiting for a clock edge; after release, a full frame 0xDEAD, 0xBEEF, 0xCAFE, 0xF00D is received correctly.
- Two back-to-back frames → o_FrameValid pulses exactly 64 cycles apart; outputs show frame 1 unchanged until frame 2 completes, then switch to all four frame-2 words in one cycle.

Source files
------------

// File: rtl/sevenseg_deserializer.sv
// sevenseg_deserializer: rebuilds 4x16-bit LSB-first groups from a serial 7-seg link into a registered frame
// Ports: i_CLK link clock; i_RESET_N async active-low reset; i_EN bit qualifier;
//        i_7SegData serial data; i_7Seg_Latch active-low group-end strobe (on bit 15);
//        o_7SegData16_0..3 last complete frame; o_FrameValid frame-update pulse; o_SyncErr framing-error pulse
module sevenseg_deserializer (
  input  logic        i_CLK,
  input  logic        i_RESET_N,
  input  logic        i_EN,
  input  logic        i_7SegData,
  input  logic        i_7Seg_Latch,
  output logic [15:0] o_7SegData16_0,
  output logic [15:0] o_7SegData16_1,
  output logic [15:0] o_7SegData16_2,
  output logic [15:0] o_7SegData16_3,
  output logic        o_FrameValid,
  output logic        o_SyncErr
);
  logic [15:0]       sh_q, sh_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [1:0]        gcnt_q, gcnt_d;
  logic [2:0][15:0]  stg_q, stg_d;
  logic [3:0][15:0]  out_q, out_d;
  logic              fv_q, fv_d, se_q, se_d;
  logic [15:0]       w;
  logic              last, lat;
  assign w    = {i_7SegData, sh_q[15:1]};
  assign last = bcnt_q == 4'd15;
  assign lat  = ~i_7Seg_Latch;
  always_comb begin
    sh_d   = sh_q;
    bcnt_d = bcnt_q;
    gcnt_d = gcnt_q;
    stg_d  = stg_q;
    out_d  = out_q;
    fv_d   = 1'b0;
    se_d   = 1'b0;
    if (i_EN) begin
      if (!last && !lat) begin
        sh_d   = w;
        bcnt_d = bcnt_q + 4'd1;
      end else if (last && lat) begin
        bcnt_d = '0;
        if (gcnt_q == 2'd3) begin
          // all four words move together so the outputs never mix frames
          out_d  = {w, stg_q};
          fv_d   = 1'b1;
          gcnt_d = '0;
        end else begin
          stg_d[gcnt_q] = w;
          gcnt_d        = gcnt_q + 2'd1;
        end
      end else begin
        // early or missing latch: drop the bit and restart at bit 0 of group 0
        se_d   = 1'b1;
        bcnt_d = '0;
        gcnt_d = '0;
      end
    end
  end
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      sh_q   <= '0;
      bcnt_q <= '0;
      gcnt_q <= '0;
      stg_q  <= '0;
      out_q  <= '0;
      fv_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcnt_q <= bcnt_d;
      gcnt_q <= gcnt_d;
      stg_q  <= stg_d;
      out_q  <= out_d;
      fv_q   <= fv_d;
      se_q   <= se_d;
    end
  end
  assign o_7SegData16_0 = out_q[0];
  assign o_7SegData16_1 = out_q[1];
  assign o_7SegData16_2 = out_q[2];
  assign o_7SegData16_3 = out_q[3];
  assign o_FrameValid   = fv_q;
  assign o_SyncErr      = se_q;
endmodule

// File: tb/tb_sevenseg_deserializer.sv
// tb_sevenseg_deserializer: scoreboard bench for the serial 7-seg frame receiver
module tb_sevenseg_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, data = 1'b0, latch = 1'b1;
  logic [15:0] o0, o1, o2, o3;
  logic fv, se;
  int checks = 0, errors = 0, cyc = 0, drv_cyc = 0;
  typedef struct {bit err; logic [3:0][15:0] w;} ev_t;
  ev_t q[$];
  int fv_cycs[$];
  logic [3:0][15:0] cur = '0;

  sevenseg_deserializer dut (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_EN(en), .i_7SegData(data), .i_7Seg_Latch(latch),
    .o_7SegData16_0(o0), .o_7SegData16_1(o1), .o_7SegData16_2(o2), .o_7SegData16_3(o3),
    .o_FrameValid(fv), .o_SyncErr(se)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) cur = '0;
    else begin
      if (fv && se) chk("fv_se_together", 64'(1), 64'(0));
      if (fv || se) begin
        if (q.size() == 0) chk("unexpected_event", {fv, se}, 64'(0));
        else begin
          e = q.pop_front();
          chk("event_is_syncerr", 64'(se), 64'(e.err));
          if (!e.err) begin
            cur = e.w;
            fv_cycs.push_back(cyc);
          end
        end
      end
      chk("outputs", {o3, o2, o1, o0}, cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic bit_(input logic d, input logic l);
    @(negedge clk);
    drv_cyc = cyc;
    en = 1'b1; data = d; latch = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; data = 1'($urandom); latch = 1'($urandom);
    end
  endtask

  task automatic send_bits(input logic [3:0][15:0] w, input int n);
    for (int i = 0; i < n; i++) bit_(w[i/16][i%16], (i % 16) != 15);
  endtask

  task automatic send_frame(input logic [3:0][15:0] w, input int ga, input int gb, output int start);
    ev_t e;
    e.err = 1'b0; e.w = w;
    q.push_back(e);
    start = -1;
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 16; b++) begin
        if (g == 0 && b == 7) idle(ga);
        if (g == 3 && b == 0) idle(gb);
        bit_(w[g][b], b != 15);
        if (start < 0) start = drv_cyc;
      end
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.w = '0;
    q.push_back(e);
  endtask

  initial begin
    logic [3:0][15:0] fa, fb, fc, fd, fe;
    int s;
    fa = {16'h8001, 16'h0F0F, 16'hABCD, 16'h1234};
    fb = {16'hFFFF, 16'h0001, 16'hAAAA, 16'h5555};
    fc = {16'h2468, 16'h1357, 16'hFFFF, 16'h0000};
    fd = {16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};
    fe = {16'h0102, 16'h0304, 16'h0506, 16'h0708};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o3, o2, o1, o0, 13'd0, fv, se}, 64'(0));
    rst_n = 1'b1;
    // clean frame: FrameValid seen 64 cycles after bit 0 is driven
    send_frame(fa, 0, 0, s);
    idle(2);
    chk("frame_latency", 64'(fv_cycs[$] - s), 64'(64));
    // early latch at bit 10 of group 1
    send_bits(fa, 26);
    push_err();
    bit_(fa[1][10], 1'b0);
    send_frame(fb, 0, 0, s);
    idle(2);
    // missing latch at bit 15 of group 2
    send_bits(fb, 47);
    push_err();
    bit_(fb[2][15], 1'b1);
    send_frame(fc, 0, 0, s);
    idle(2);
    // EN gaps of 3 and 5 cycles delay FrameValid by 8
    send_frame(fa, 3, 5, s);
    idle(2);
    chk("gap_latency", 64'(fv_cycs[$] - s), 64'(72));
    // async reset after 40 bits while outputs hold fa
    send_bits(fc, 40);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {o3, o2, o1, o0}, 64'(0));
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(fd, 0, 0, s);
    idle(2);
    // back-to-back frames
    send_frame(fb, 0, 0, s);
    send_frame(fe, 0, 0, s);
    idle(3);
    chk("b2b_spacing", 64'(fv_cycs[$] - fv_cycs[$-1]), 64'(64));
    chk("all_events_seen", 64'(q.size()), 64'(0));
    chk("frame_count", 64'(fv_cycs.size()), 64'(7));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
